// File: rtl/usb_buf_pkg.sv
// Shared definitions for the USB packet-buffer arbiter: buffer size and the
// ownership state encoding that is also reported to the host as buf_mode.
package usb_buf_pkg;

  localparam int DEPTH_DEFAULT = 64;
  localparam int OCC_W_DEFAULT = $clog2(DEPTH_DEFAULT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_FILL  = 3'd1,
    RX_READY = 3'd2,
    TX_FILL  = 3'd3,
    TX_SEND  = 3'd4
  } buf_state_t;

endpackage

// File: rtl/buffer_arbiter_if.sv
// Bundle of every signal between the arbiter and its neighbours: host register
// block, USB RX/TX engines and the 64-byte buffer.
interface buffer_arbiter_if #(
  parameter int OCC_W = 7
);
  logic [OCC_W-1:0] buff_occ;
  logic             host_clear;
  logic             h_store;
  logic [7:0]       h_data;
  logic             h_get;
  logic             h_tx_go;
  logic             rx_store;
  logic [7:0]       rx_byte;
  logic             rx_packet_done;
  logic             rx_error;
  logic             tx_get;
  logic             tx_packet_done;
  logic             clear;
  logic             flush;
  logic             store_tx_data;
  logic [7:0]       tx_data;
  logic             store_rx_data;
  logic [7:0]       RX_packet_data;
  logic             get_tx_data;
  logic             get_rx_data;
  logic             tx_start;
  logic             rx_data_ready;
  logic             h_stall;
  logic             rx_overflow;
  logic [2:0]       buf_mode;

  // The arbiter itself.
  modport master (
    input  buff_occ, host_clear, h_store, h_data, h_get, h_tx_go,
           rx_store, rx_byte, rx_packet_done, rx_error, tx_get, tx_packet_done,
    output clear, flush, store_tx_data, tx_data, store_rx_data, RX_packet_data,
           get_tx_data, get_rx_data, tx_start, rx_data_ready, h_stall,
           rx_overflow, buf_mode
  );

  // Everything around it: requesters and the buffer.
  modport slave (
    output buff_occ, host_clear, h_store, h_data, h_get, h_tx_go,
           rx_store, rx_byte, rx_packet_done, rx_error, tx_get, tx_packet_done,
    input  clear, flush, store_tx_data, tx_data, store_rx_data, RX_packet_data,
           get_tx_data, get_rx_data, tx_start, rx_data_ready, h_stall,
           rx_overflow, buf_mode
  );

endinterface

// File: rtl/occ_tracker.sv
// Effective buffer occupancy: the buffer's own count corrected for the store/get
// strobe issued last cycle, which the buffer has not yet accounted for.
module occ_tracker #(
  parameter int DEPTH = 64,
  parameter int OCC_W = 7
) (
  input  logic [OCC_W-1:0] buff_occ_i,
  input  logic             pend_store_i,
  input  logic             pend_get_i,
  output logic [OCC_W:0]   eff_occ_o,
  output logic             full_o,
  output logic             empty_o
);

  // One extra bit so buff_occ + 1 never wraps.
  assign eff_occ_o = {1'b0, buff_occ_i}
                   + {{OCC_W{1'b0}}, pend_store_i}
                   - {{OCC_W{1'b0}}, pend_get_i};

  assign full_o  = (eff_occ_o == (OCC_W + 1)'(DEPTH));
  assign empty_o = (eff_occ_o == '0);

endmodule

// File: rtl/buffer_arbiter.sv
// Ownership FSM for the shared packet buffer: sequences RX and TX fill/drain
// cycles and drives registered buffer strobes plus a same-cycle host stall.
module buffer_arbiter
  import usb_buf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int OCC_W = OCC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              n_rst,
  buffer_arbiter_if.master  bus
);

  buf_state_t     state_q;
  logic           clear_q, flush_q, tx_start_q, ovf_q;
  logic           store_tx_q, store_rx_q, get_tx_q, get_rx_q;
  logic [7:0]     tx_data_q, rx_data_q;

  logic [OCC_W:0] eff_occ;
  logic           full, empty;

  occ_tracker #(.DEPTH(DEPTH), .OCC_W(OCC_W)) u_occ (
    .buff_occ_i   (bus.buff_occ),
    .pend_store_i (store_tx_q | store_rx_q),
    .pend_get_i   (get_tx_q | get_rx_q),
    .eff_occ_o    (eff_occ),
    .full_o       (full),
    .empty_o      (empty)
  );

  logic host_req, rx_acc, tx_get_acc;
  assign host_req   = bus.h_store | bus.h_get | bus.h_tx_go;
  assign rx_acc     = bus.rx_store & ~full;
  assign tx_get_acc = bus.tx_get & ~empty;

  always_comb begin
    // NOTE: default first so every path assigns h_stall and no latch is inferred.
    bus.h_stall = 1'b0;
    if (!bus.host_clear) begin
      case (state_q)
        IDLE:             bus.h_stall = bus.h_store & bus.rx_store;
        RX_FILL, TX_SEND: bus.h_stall = host_req;
        RX_READY:         bus.h_stall = bus.h_store | (bus.h_get & empty);
        TX_FILL:          bus.h_stall = bus.h_store & full;
        default:          bus.h_stall = 1'b0;
      endcase
    end
  end

  // NOTE: non-blocking assignments throughout; the strobe defaults at the top
  // are overridden by later assignments in the same cycle, giving 1-cycle pulses.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      clear_q    <= 1'b0;
      flush_q    <= 1'b0;
      tx_start_q <= 1'b0;
      ovf_q      <= 1'b0;
      store_tx_q <= 1'b0;
      store_rx_q <= 1'b0;
      get_tx_q   <= 1'b0;
      get_rx_q   <= 1'b0;
      tx_data_q  <= '0;
      rx_data_q  <= '0;
    end else begin
      clear_q    <= 1'b0;
      flush_q    <= 1'b0;
      tx_start_q <= 1'b0;
      store_tx_q <= 1'b0;
      store_rx_q <= 1'b0;
      get_tx_q   <= 1'b0;
      get_rx_q   <= 1'b0;
      tx_data_q  <= '0;
      rx_data_q  <= '0;

      if (bus.host_clear) begin
        clear_q <= 1'b1;
        ovf_q   <= 1'b0;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.rx_store) begin
              store_rx_q <= 1'b1;
              rx_data_q  <= bus.rx_byte;
              state_q    <= RX_FILL;
            end else if (bus.h_store) begin
              store_tx_q <= 1'b1;
              tx_data_q  <= bus.h_data;
              state_q    <= TX_FILL;
            end
          end
          RX_FILL: begin
            if (rx_acc) begin
              store_rx_q <= 1'b1;
              rx_data_q  <= bus.rx_byte;
            end else if (bus.rx_store) begin
              ovf_q <= 1'b1;
            end
            // A byte accepted this cycle counts toward the finished packet.
            if (bus.rx_packet_done) begin
              state_q <= (!empty || rx_acc) ? RX_READY : IDLE;
            end else if (bus.rx_error) begin
              flush_q <= 1'b1;
              state_q <= IDLE;
            end
          end
          RX_READY: begin
            if (bus.h_get && !empty) get_rx_q <= 1'b1;
            if (empty) state_q <= IDLE;
          end
          TX_FILL: begin
            if (bus.h_store && !full) begin
              store_tx_q <= 1'b1;
              tx_data_q  <= bus.h_data;
            end
            if (bus.rx_store) ovf_q <= 1'b1;
            if (bus.h_tx_go) begin
              tx_start_q <= 1'b1;
              state_q    <= TX_SEND;
            end
          end
          TX_SEND: begin
            if (tx_get_acc) get_tx_q <= 1'b1;
            if (bus.tx_packet_done) begin
              flush_q <= (eff_occ > (OCC_W + 1)'(tx_get_acc));
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.clear          = clear_q;
  assign bus.flush          = flush_q;
  assign bus.store_tx_data  = store_tx_q;
  assign bus.tx_data        = tx_data_q;
  assign bus.store_rx_data  = store_rx_q;
  assign bus.RX_packet_data = rx_data_q;
  assign bus.get_tx_data    = get_tx_q;
  assign bus.get_rx_data    = get_rx_q;
  assign bus.tx_start       = tx_start_q;
  assign bus.rx_data_ready  = (state_q == RX_READY);
  assign bus.rx_overflow    = ovf_q;
  assign bus.buf_mode       = state_q;

endmodule

// File: tb/tb_buffer_arbiter.sv
// Bench for buffer_arbiter: a vector table, directed packet sequences and a
// random run checked against a queue-based model of the buffer's contents.
module tb_buffer_arbiter;

  localparam int DEPTH = 64;
  localparam int OCC_W = 7;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  buffer_arbiter_if #(.OCC_W(OCC_W)) bus ();
  buffer_arbiter #(.DEPTH(DEPTH), .OCC_W(OCC_W)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  // Simple buffer: count changes one edge after each strobe seen on its pins.
  int buf_cnt = 0;
  always @(posedge clk) begin
    if (!n_rst || bus.clear || bus.flush) buf_cnt <= 0;
    else buf_cnt <= buf_cnt + int'(bus.store_tx_data | bus.store_rx_data)
                            - int'(bus.get_tx_data | bus.get_rx_data);
  end
  assign bus.buff_occ = OCC_W'(buf_cnt);

  typedef struct packed {
    logic host_clear, h_store, h_get, h_tx_go, rx_store;
    logic rx_packet_done, rx_error, tx_get, tx_packet_done;
    logic [7:0] h_data, rx_byte;
  } stim_t;

  typedef struct packed {
    logic clear, flush, store_tx;
    logic [7:0] tx_data;
    logic store_rx;
    logic [7:0] rx_data;
    logic get_tx, get_rx, tx_start, rx_ready, ovf;
    logic [2:0] mode;
  } out_t;

  localparam logic [8:0] F_CLR = 9'h100, F_HST = 9'h080, F_HGET = 9'h040,
                         F_GO  = 9'h020, F_RXS = 9'h010, F_DONE = 9'h008,
                         F_ERR = 9'h004, F_TXG = 9'h002, F_TXD  = 9'h001;

  function automatic stim_t mk(input logic [8:0] f, input logic [7:0] hd, input logic [7:0] rd);
    return {f, hd, rd};
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic out_t dut_out();
    return {bus.clear, bus.flush, bus.store_tx_data, bus.tx_data, bus.store_rx_data,
            bus.RX_packet_data, bus.get_tx_data, bus.get_rx_data, bus.tx_start,
            bus.rx_data_ready, bus.rx_overflow, bus.buf_mode};
  endfunction

  function automatic logic [6:0] dut_strb();
    return {bus.clear, bus.flush, bus.store_tx_data, bus.store_rx_data,
            bus.get_tx_data, bus.get_rx_data, bus.tx_start};
  endfunction

  // Reference model: who owns the buffer and which bytes it holds right now.
  typedef enum int {M_IDLE = 0, M_RX_FILL = 1, M_RX_READY = 2, M_TX_FILL = 3, M_TX_SEND = 4} mstate_t;
  mstate_t    m_st;
  logic       m_ovf;
  logic [7:0] m_q[$];
  out_t       exp_out;

  task automatic model_reset();
    m_q.delete();
    m_st  = M_IDLE;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input stim_t s, output logic stall);
    int   n;
    logic full, empty;
    n       = m_q.size();
    full    = (n == DEPTH);
    empty   = (n == 0);
    exp_out = '0;
    stall   = 1'b0;
    if (s.host_clear) begin
      exp_out.clear = 1'b1;
      m_q.delete();
      m_ovf = 1'b0;
      m_st  = M_IDLE;
    end else begin
      case (m_st)
        M_IDLE: begin
          if (s.rx_store) begin
            m_q.push_back(s.rx_byte);
            exp_out.store_rx = 1'b1;
            exp_out.rx_data  = s.rx_byte;
            stall = s.h_store;
            m_st  = M_RX_FILL;
          end else if (s.h_store) begin
            m_q.push_back(s.h_data);
            exp_out.store_tx = 1'b1;
            exp_out.tx_data  = s.h_data;
            m_st = M_TX_FILL;
          end
        end
        M_RX_FILL: begin
          stall = s.h_store | s.h_get | s.h_tx_go;
          if (s.rx_store) begin
            if (!full) begin
              m_q.push_back(s.rx_byte);
              exp_out.store_rx = 1'b1;
              exp_out.rx_data  = s.rx_byte;
            end else m_ovf = 1'b1;
          end
          if (s.rx_packet_done) m_st = (m_q.size() > 0) ? M_RX_READY : M_IDLE;
          else if (s.rx_error) begin
            exp_out.flush = 1'b1;
            m_q.delete();
            m_st = M_IDLE;
          end
        end
        M_RX_READY: begin
          if (s.h_store) stall = 1'b1;
          if (s.h_get) begin
            if (!empty) begin
              void'(m_q.pop_front());
              exp_out.get_rx = 1'b1;
            end else stall = 1'b1;
          end
          if (empty) m_st = M_IDLE;
        end
        M_TX_FILL: begin
          if (s.h_store) begin
            if (!full) begin
              m_q.push_back(s.h_data);
              exp_out.store_tx = 1'b1;
              exp_out.tx_data  = s.h_data;
            end else stall = 1'b1;
          end
          if (s.rx_store) m_ovf = 1'b1;
          if (s.h_tx_go) begin
            exp_out.tx_start = 1'b1;
            m_st = M_TX_SEND;
          end
        end
        M_TX_SEND: begin
          stall = s.h_store | s.h_get | s.h_tx_go;
          if (s.tx_get && !empty) begin
            void'(m_q.pop_front());
            exp_out.get_tx = 1'b1;
          end
          if (s.tx_packet_done) begin
            if (m_q.size() != 0) begin
              exp_out.flush = 1'b1;
              m_q.delete();
            end
            m_st = M_IDLE;
          end
        end
        default: m_st = M_IDLE;
      endcase
    end
    exp_out.ovf      = m_ovf;
    exp_out.rx_ready = (m_st == M_RX_READY);
    exp_out.mode     = 3'(m_st);
  endtask

  task automatic apply(input stim_t s);
    bus.host_clear     = s.host_clear;
    bus.h_store        = s.h_store;
    bus.h_data         = s.h_data;
    bus.h_get          = s.h_get;
    bus.h_tx_go        = s.h_tx_go;
    bus.rx_store       = s.rx_store;
    bus.rx_byte        = s.rx_byte;
    bus.rx_packet_done = s.rx_packet_done;
    bus.rx_error       = s.rx_error;
    bus.tx_get         = s.tx_get;
    bus.tx_packet_done = s.tx_packet_done;
  endtask

  // One cycle: drive at negedge, check the stall mid-cycle, check registers after the edge.
  logic last_stall;
  task automatic step(input stim_t s);
    logic es;
    @(negedge clk);
    apply(s);
    #1;
    last_stall = bus.h_stall;
    model_step(s, es);
    check("h_stall", 32'(last_stall), 32'(es));
    @(posedge clk);
    #1;
    check("regs", 32'(dut_out()), 32'(exp_out));
  endtask

  task automatic go_idle();
    step(mk(F_CLR, 8'h00, 8'h00));
    step(mk(9'h000, 8'h00, 8'h00));
  endtask

  typedef struct {
    stim_t      s;
    logic       stall;
    logic [2:0] mode;
    logic [6:0] strb;   // {clear, flush, store_tx, store_rx, get_tx, get_rx, tx_start}
  } vec_t;
  vec_t vt[13];

  initial begin
    #(200_000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    stim_t s;
    apply('0);
    n_rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_regs", 32'(dut_out()), 32'h0);
    check("reset_stall", 32'(bus.h_stall), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;

    // Contention, abort and a short TX packet from a clean reset.
    vt[0]  = '{mk(9'h000, 8'h00, 8'h00), 1'b0, 3'd0, 7'b0000000};
    vt[1]  = '{mk(F_RXS | F_HST, 8'h55, 8'hAA), 1'b1, 3'd1, 7'b0001000};
    vt[2]  = '{mk(F_RXS, 8'h00, 8'hBB), 1'b0, 3'd1, 7'b0001000};
    vt[3]  = '{mk(F_HGET, 8'h00, 8'h00), 1'b1, 3'd1, 7'b0000000};
    vt[4]  = '{mk(F_ERR, 8'h00, 8'h00), 1'b0, 3'd0, 7'b0100000};
    vt[5]  = '{mk(F_HST, 8'h11, 8'h00), 1'b0, 3'd3, 7'b0010000};
    vt[6]  = '{mk(F_HST, 8'h22, 8'h00), 1'b0, 3'd3, 7'b0010000};
    vt[7]  = '{mk(F_HGET, 8'h00, 8'h00), 1'b0, 3'd3, 7'b0000000};
    vt[8]  = '{mk(F_GO, 8'h00, 8'h00), 1'b0, 3'd4, 7'b0000001};
    vt[9]  = '{mk(F_TXG, 8'h00, 8'h00), 1'b0, 3'd4, 7'b0000100};
    vt[10] = '{mk(F_HST, 8'h33, 8'h00), 1'b1, 3'd4, 7'b0000000};
    vt[11] = '{mk(F_TXD, 8'h00, 8'h00), 1'b0, 3'd0, 7'b0100000};
    vt[12] = '{mk(9'h000, 8'h00, 8'h00), 1'b0, 3'd0, 7'b0000000};
    for (int i = 0; i < 13; i++) begin
      step(vt[i].s);
      check($sformatf("vec%0d_stall", i), 32'(last_stall), 32'(vt[i].stall));
      check($sformatf("vec%0d_mode", i), 32'(bus.buf_mode), 32'(vt[i].mode));
      check($sformatf("vec%0d_strb", i), 32'(dut_strb()), 32'(vt[i].strb));
    end

    // RX packet then host drains it.
    go_idle();
    step(mk(F_RXS, 8'h00, 8'hDE));
    check("rx_byte0", 32'(bus.RX_packet_data), 32'hDE);
    step(mk(F_RXS, 8'h00, 8'hAD));
    check("rx_byte1", 32'(bus.RX_packet_data), 32'hAD);
    step(mk(F_RXS, 8'h00, 8'h01));
    check("rx_byte2", 32'(bus.RX_packet_data), 32'h01);
    step(mk(F_DONE, 8'h00, 8'h00));
    check("rx_ready_mode", 32'(bus.buf_mode), 32'd2);
    check("rx_data_ready", 32'(bus.rx_data_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(mk(F_HGET, 8'h00, 8'h00));
      check($sformatf("get_rx%0d", i), 32'(bus.get_rx_data), 32'd1);
    end
    for (int k = 0; k < 4 && bus.buf_mode != 3'd0; k++) step(mk(9'h000, 8'h00, 8'h00));
    check("rx_drain_idle", 32'(bus.buf_mode), 32'd0);

    // TX packet.
    go_idle();
    for (int i = 0; i < 4; i++) begin
      step(mk(F_HST, 8'(8'h10 + i), 8'h00));
      check($sformatf("tx_data%0d", i), 32'(bus.tx_data), 32'(8'h10 + i));
    end
    step(mk(F_GO, 8'h00, 8'h00));
    check("tx_start_pulse", 32'(bus.tx_start), 32'd1);
    check("tx_send_mode", 32'(bus.buf_mode), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(mk(F_TXG, 8'h00, 8'h00));
      check($sformatf("get_tx%0d", i), 32'(bus.get_tx_data), 32'd1);
      if (i == 0) check("tx_start_one_cycle", 32'(bus.tx_start), 32'd0);
    end
    step(mk(F_TXD, 8'h00, 8'h00));
    check("tx_done_noflush", 32'(bus.flush), 32'd0);
    check("tx_done_idle", 32'(bus.buf_mode), 32'd0);

    // RX overflow, then software clear.
    go_idle();
    cnt = 0;
    for (int i = 0; i < 65; i++) begin
      step(mk(F_RXS, 8'h00, 8'(i)));
      cnt += int'(bus.store_rx_data);
    end
    check("ovf_store_count", 32'(cnt), 32'd64);
    check("ovf_flag", 32'(bus.rx_overflow), 32'd1);
    step(mk(F_CLR, 8'h00, 8'h00));
    check("clr_pulse", 32'(bus.clear), 32'd1);
    check("clr_ovf", 32'(bus.rx_overflow), 32'd0);
    check("clr_mode", 32'(bus.buf_mode), 32'd0);

    // Abort, then the host may take the buffer.
    go_idle();
    for (int i = 0; i < 5; i++) step(mk(F_RXS, 8'h00, 8'(8'hA0 + i)));
    step(mk(F_ERR, 8'h00, 8'h00));
    check("abort_flush", 32'(bus.flush), 32'd1);
    check("abort_idle", 32'(bus.buf_mode), 32'd0);
    step(mk(F_HST, 8'h77, 8'h00));
    check("abort_then_tx", 32'(bus.buf_mode), 32'd3);
    check("abort_then_store", 32'(bus.store_tx_data), 32'd1);

    // Reset while sending with ten bytes buffered.
    go_idle();
    for (int i = 0; i < 10; i++) step(mk(F_HST, 8'(i), 8'h00));
    step(mk(F_GO, 8'h00, 8'h00));
    step(mk(9'h000, 8'h00, 8'h00));
    check("pre_reset_mode", 32'(bus.buf_mode), 32'd4);
    check("pre_reset_occ", 32'(bus.buff_occ), 32'd10);
    @(negedge clk);
    apply('0);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_regs", 32'(dut_out()), 32'h0);
    check("mid_reset_stall", 32'(bus.h_stall), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      s.host_clear     = ($urandom_range(0, 199) == 0);
      s.h_store        = ($urandom_range(0, 99) < 30);
      s.h_get          = ($urandom_range(0, 99) < 25);
      s.h_tx_go        = ($urandom_range(0, 99) < 4);
      s.rx_store       = ($urandom_range(0, 99) < 35);
      s.rx_packet_done = ($urandom_range(0, 99) < 4);
      s.rx_error       = ($urandom_range(0, 99) < 2);
      s.tx_get         = ($urandom_range(0, 99) < 40);
      s.tx_packet_done = ($urandom_range(0, 99) < 4);
      s.h_data         = 8'($urandom);
      s.rx_byte        = 8'($urandom);
      step(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer_arbiter.md
Name: buffer_arbiter

Overview:
Owns the shared 64-byte data buffer and decides which side may use it at any time. The requesters are the AHB host side and the USB RX/TX protocol engines. It sequences the buffer through a fill/drain cycle for each packet, drives the buffer's store, get, clear and flush strobes, and reports ownership and status to the host register block. It sits between the AHB slave, the RX/TX packet engines and the buffer.

Parameters:
DEPTH, 64, buffer capacity in bytes
OCC_W, 7, width of the occupancy count (must hold 0..DEPTH)

Ports:
clk  in  1  system clock
n_rst  in  1  reset
buff_occ  in  OCC_W  current buffer occupancy
host_clear  in  1  software clear request (pulse)
h_store  in  1  host write-byte request
h_data  in  8  host write byte
h_get  in  1  host read-byte request
h_tx_go  in  1  host commands transmit of the buffered packet (pulse)
rx_store  in  1  USB RX engine byte-valid strobe
rx_byte  in  8  USB RX received byte
rx_packet_done  in  1  RX packet ended with good CRC (pulse)
rx_error  in  1  RX packet aborted or CRC bad (pulse)
tx_get  in  1  USB TX engine byte request
tx_packet_done  in  1  TX engine finished packet (pulse)
clear  out  1  buffer clear strobe
flush  out  1  buffer flush strobe
store_tx_data  out  1  buffer host-write strobe
tx_data  out  8  buffer host-write byte
store_rx_data  out  1  buffer USB-write strobe
RX_packet_data  out  8  buffer USB-write byte
get_tx_data  out  1  buffer TX-read strobe
get_rx_data  out  1  buffer host-read strobe
tx_start  out  1  one-cycle pulse to the TX engine
rx_data_ready  out  1  a received packet is waiting for the host
h_stall  out  1  the host request this cycle was not accepted
rx_overflow  out  1  sticky flag: an RX byte was dropped because the buffer was full
buf_mode  out  3  current state encoding

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on n_rst.
- Reset: state IDLE; all outputs 0.
- Registered outputs: every buffer-side output (strobes and data) is registered. A request accepted in cycle N appears on the buffer pins in cycle N+1, as a 1-cycle strobe per request.
- Effective occupancy: eff_occ = buff_occ + pending store − pending get, where pending means a strobe issued last cycle. All full/empty decisions use eff_occ.
  - Full means eff_occ == DEPTH.
  - Empty means eff_occ == 0.
- States:
  - IDLE (0)
  - RX_FILL (1)
  - RX_READY (2)
  - TX_FILL (3)
  - TX_SEND (4)
- IDLE:
  - rx_store → forward the byte, go to RX_FILL.
  - else h_store → forward the byte, go to TX_FILL.
  - If rx_store and h_store arrive together, RX wins, the host byte is dropped and h_stall=1.
  - h_get and h_tx_go are ignored in IDLE.
- RX_FILL:
  - rx_store is forwarded when not full. When full, the byte is dropped and rx_overflow is set.
  - rx_packet_done → RX_READY if eff_occ > 0, else IDLE.
  - rx_error → flush pulse, go to IDLE.
  - Any host request → h_stall=1.
- RX_READY:
  - rx_data_ready=1.
  - h_get is forwarded as get_rx_data when not empty. h_get when empty → h_stall=1.
  - When eff_occ reaches 0 → IDLE.
  - h_store and rx_store are ignored in RX_READY; h_store also sets h_stall=1.
- TX_FILL:
  - h_store is forwarded when not full. When full, the byte is dropped and h_stall=1.
  - h_tx_go → tx_start pulse in the next cycle, go to TX_SEND.
  - rx_store is dropped, and rx_overflow is set (the buffer is busy).
- TX_SEND:
  - tx_get is forwarded as get_tx_data when not empty; when empty it is ignored.
  - tx_packet_done → IDLE, plus a flush pulse if eff_occ != 0.
  - Host requests → h_stall=1.
- host_clear has top priority in any state:
  - clear pulse;
  - state goes to IDLE;
  - rx_overflow is cleared;
  - all other requests in that cycle are ignored.
- Simultaneous events within a state: terminal events (done/error/go) are evaluated after that cycle's byte strobe, so a byte arriving in the same cycle is still forwarded.
- h_stall is combinational: it is valid in the same cycle as the request.

Decomposition:
- Package usb_buf_pkg holds:
  - the state enum buf_state_t with its 3-bit encoding;
  - DEPTH_DEFAULT = 64.
- One natural sub-module, occ_tracker, computes eff_occ and the full/empty flags from buff_occ and the pending strobes.
- The top level contains the FSM and the output registers.

Test Plan:
- RX packet: 3 rx_store (0xDE, 0xAD, 0x01), then rx_packet_done → RX_READY with rx_data_ready=1. Then 3 h_get → get_rx_data pulses 1 cycle after each request, followed by IDLE.
- TX packet: 4 h_store, then h_tx_go → tx_start pulses for exactly 1 cycle, state TX_SEND. Then 4 tx_get and tx_packet_done → IDLE with no flush.
- Overflow: 65 back-to-back rx_store → exactly 64 store_rx_data pulses and rx_overflow=1. Then host_clear → clear pulse, rx_overflow=0, IDLE.
- Contention: in IDLE, rx_store and h_store in the same cycle → store_rx_data=1, store_tx_data=0, h_stall=1, state RX_FILL.
- Abort: 5 rx_store, then rx_error → flush pulse, then IDLE. A later h_store is accepted and goes to TX_FILL.
- Reset mid-TX_SEND with buff_occ=10: n_rst low for one clock edge → all outputs 0 and state IDLE on the next cycle.
